// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised synchronous up/down counter with parallel load, count enable,
// wrap/saturate boundary mode and a registered terminal-count pulse.
//
// Parameters
//   WIDTH      counter width in bits (1..32)
//   MAX        top count value, modulus is MAX+1 (1 <= MAX <= 2**WIDTH-1)
//   RESET_VAL  value taken while reset is held (RESET_VAL <= MAX)
//
// Ports
//   clk       in   1      clock, all state changes on the rising edge
//   rst       in   1      asynchronous reset, active low
//   en        in   1      count enable
//   up        in   1      direction, 1 = up, 0 = down
//   sat       in   1      boundary mode, 0 = wrap, 1 = saturate
//   load      in   1      synchronous parallel load, highest priority
//   load_val  in   WIDTH  value to load, clamped to MAX
//   out       out  WIDTH  registered count value, always within 0..MAX
//   tc        out  1      registered terminal-count pulse
//   zero      out  1      combinational (out == 0)
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MAX       = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             zero
);

    // Parameters are carried as 64-bit values so the default MAX stays exact
    // for WIDTH=32; the counter itself only ever works in WIDTH bits.
    localparam logic [WIDTH-1:0] TOP   = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] START = RESET_VAL[WIDTH-1:0];

    // Loaded values above the modulus are pulled back to TOP so the count can
    // never sit in the unreachable encodings above MAX.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return (v > TOP) ? TOP : v;
    endfunction

    logic [WIDTH-1:0] next_out;
    logic             next_tc;

    always_comb begin
        next_out = out;
        next_tc  = 1'b0;
        if (load) begin
            next_out = clamp(load_val);
        end else if (en) begin
            if (up) begin
                if (out == TOP) begin
                    // Boundary event: wrap to 0 or hold at TOP, pulse either way.
                    next_out = sat ? TOP : '0;
                    next_tc  = 1'b1;
                end else begin
                    next_out = out + 1'b1;
                end
            end else begin
                if (out == '0) begin
                    next_out = sat ? '0 : TOP;
                    next_tc  = 1'b1;
                end else begin
                    next_out = out - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= START;
            tc  <= 1'b0;
        end else begin
            out <= next_out;
            tc  <= next_tc;
        end
    end

    assign zero = (out == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [3:0] load_val;

    // dut_a: WIDTH=4, default MAX=15.  dut_b: WIDTH=4, MAX=9.
    logic [3:0] out_a, out_b;
    logic       tc_a, tc_b;
    logic       zero_a, zero_b;

    updown_counter_param #(.WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val),
        .out(out_a), .tc(tc_a), .zero(zero_a)
    );

    updown_counter_param #(.WIDTH(4), .MAX(9)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val),
        .out(out_b), .tc(tc_b), .zero(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic [3:0] o;
        logic       t;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0b required %0b", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the result expected after the edge.
    task automatic step(input int d, input bit l, input logic [3:0] lv,
                        input bit e, input bit u, input bit s,
                        input logic [3:0] eo, input bit et, input string nm);
        exp_t x;
        @(negedge clk);
        load = l; load_val = lv; en = e; up = u; sat = s;
        x.d = d; x.o = eo; x.t = et; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; sat = 1'b0; load_val = 4'd0;
        repeat (5) @(negedge clk);
        chk4({nm, ".a.out"}, out_a, 4'd0);
        chk1({nm, ".a.tc"}, tc_a, 1'b0);
        chk1({nm, ".a.zero"}, zero_a, 1'b1);
        chk4({nm, ".b.out"}, out_b, 4'd0);
        chk1({nm, ".b.tc"}, tc_b, 1'b0);
        rst = 1'b1;
    endtask

    // Monitor: after every rising edge, pop and compare the pending expectation.
    initial begin
        exp_t       x;
        logic [3:0] ao;
        logic       at, az;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x  = sb.pop_front();
                ao = (x.d == 0) ? out_a  : out_b;
                at = (x.d == 0) ? tc_a   : tc_b;
                az = (x.d == 0) ? zero_a : zero_b;
                chk4({x.nm, ".out"}, ao, x.o);
                chk1({x.nm, ".tc"}, at, x.t);
                chk1({x.nm, ".zero"}, az, (x.o == 4'd0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b0; sat = 1'b0; load = 1'b0; load_val = 4'd0;

        // Count down with wrap on MAX=15: 15,14,...,0,15,14,13,12.
        do_reset("rst1");
        for (int i = 0; i < 20; i++)
            step(0, 0, 4'd0, 1, 0, 0, 4'(15 - (i % 16)), (i % 16) == 0, $sformatf("down15[%0d]", i));

        // Count up with wrap on MAX=9: 1..9,0,1,2.
        do_reset("rst2");
        for (int i = 0; i < 12; i++)
            step(1, 0, 4'd0, 1, 1, 0, 4'((i + 1) % 10), i == 9, $sformatf("up9[%0d]", i));

        // Saturate at top on MAX=15, then reverse without tc.
        step(0, 1, 4'd14, 0, 1, 1, 4'd14, 0, "sat.load14");
        step(0, 0, 4'd0,  1, 1, 1, 4'd15, 0, "sat.up0");
        step(0, 0, 4'd0,  1, 1, 1, 4'd15, 1, "sat.up1");
        step(0, 0, 4'd0,  1, 1, 1, 4'd15, 1, "sat.up2");
        step(0, 0, 4'd0,  1, 1, 1, 4'd15, 1, "sat.up3");
        step(0, 0, 4'd0,  1, 0, 1, 4'd14, 0, "sat.rev");

        // Saturate at zero on MAX=9, tc drops once en goes low.
        step(1, 1, 4'd1, 0, 0, 1, 4'd1, 0, "satz.load1");
        step(1, 0, 4'd0, 1, 0, 1, 4'd0, 0, "satz.dn0");
        step(1, 0, 4'd0, 1, 0, 1, 4'd0, 1, "satz.dn1");
        step(1, 0, 4'd0, 0, 0, 1, 4'd0, 0, "satz.hold");

        // Load clamp and priority over en on MAX=9.
        step(1, 1, 4'd13, 1, 1, 0, 4'd9, 0, "ld.clamp13");
        step(1, 1, 4'd3,  1, 1, 0, 4'd3, 0, "ld.3");
        step(1, 0, 4'd0,  0, 1, 0, 4'd3, 0, "ld.hold0");
        step(1, 0, 4'd0,  0, 1, 0, 4'd3, 0, "ld.hold1");
        step(1, 0, 4'd0,  0, 1, 0, 4'd3, 0, "ld.hold2");
        step(1, 1, 4'd9,  0, 0, 0, 4'd9, 0, "rev.load9");
        step(1, 0, 4'd0,  1, 0, 0, 4'd8, 0, "rev.down");
        step(1, 1, 4'd0,  0, 0, 0, 4'd0, 0, "wrapz.load0");
        step(1, 0, 4'd0,  1, 0, 0, 4'd9, 1, "wrapz.down");

        // Asynchronous reset in the middle of counting.
        do_reset("rst3");
        for (int i = 0; i < 7; i++)
            step(0, 0, 4'd0, 1, 1, 0, 4'(i + 1), 0, $sformatf("mid.up[%0d]", i));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk4("arst.out", out_a, 4'd0);
        chk1("arst.tc", tc_a, 1'b0);
        chk1("arst.zero", zero_a, 1'b1);
        @(posedge clk);
        #1;
        chk4("arst.held", out_a, 4'd0);
        @(negedge clk);
        begin
            exp_t x;
            rst = 1'b1;
            x.d = 0; x.o = 4'd1; x.t = 1'b0; x.nm = "resume0";
            sb.push_back(x);
        end
        step(0, 0, 4'd0, 1, 1, 0, 4'd2, 0, "resume1");
        step(0, 0, 4'd0, 1, 1, 0, 4'd3, 0, "resume2");

        // zero flag tracks out with no lag.
        step(0, 1, 4'd2, 0, 0, 0, 4'd2, 0, "zero.load2");
        step(0, 0, 4'd0, 1, 0, 0, 4'd1, 0, "zero.dn1");
        step(0, 0, 4'd0, 1, 0, 0, 4'd0, 0, "zero.dn0");

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
